// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use stall, branch flush,
// data-memory freeze with watchdog, and a saturating stall-cycle counter.
module pipe_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rd_e,
   input  logic             memread_e,
   input  logic             pcsrc_e,
   input  logic             dmem_req_m,
   input  logic             dmem_ready_m,
   output logic             en_f,
   output logic             en_d,
   output logic             en_e,
   output logic             en_m,
   output logic             en_w,
   output logic             flush_d,
   output logic             flush_e,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   localparam logic [7:0] WLAST = 8'(TIMEOUT - 1);

   state_t           state_r;
   logic [7:0]       wcnt_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             mem_err_r;
   logic             lwstall_s;
   logic             freeze_s;

   // Hazard detection terms
   always_comb begin
      lwstall_s = memread_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
      freeze_s  = dmem_req_m && !dmem_ready_m;
   end

   // Stage enables and flushes, combinational so they qualify the current edge
   always_comb begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      en_m    = 1'b0;
      en_w    = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (reset || (state_r == S_ERR)) begin
         en_f = 1'b0;
      end else if (freeze_s) begin
         // E is frozen, so a pending redirect or load-use waits for release
         en_f = 1'b0;
      end else begin
         en_f    = !lwstall_s;
         en_d    = !lwstall_s;
         en_e    = 1'b1;
         en_m    = 1'b1;
         en_w    = 1'b1;
         flush_d = pcsrc_e;
         flush_e = lwstall_s || pcsrc_e;
      end
   end

   // Wait-state FSM with watchdog, sticky error, and stall counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= S_RUN;
         wcnt_r      <= 8'd0;
         mem_err_r   <= 1'b0;
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (!en_d && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         case (state_r)
            S_RUN: begin
               if (freeze_s) begin
                  state_r <= S_WAIT;
                  wcnt_r  <= 8'd1;
               end else begin
                  state_r <= S_RUN;
                  wcnt_r  <= 8'd0;
               end
            end
            S_WAIT: begin
               if (!freeze_s) begin
                  state_r <= S_RUN;
                  wcnt_r  <= 8'd0;
               end else if (wcnt_r == WLAST) begin
                  state_r   <= S_ERR;
                  mem_err_r <= 1'b1;
               end else begin
                  wcnt_r <= wcnt_r + 8'd1;
               end
            end
            S_ERR: begin
               state_r   <= S_ERR;
               mem_err_r <= 1'b1;
            end
            default: begin
               // Unreachable encoding: treat as a fault and stop the pipeline
               state_r   <= S_ERR;
               mem_err_r <= 1'b1;
            end
         endcase
      end
   end

   assign mem_err   = mem_err_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed checks of pipe_ctrl (two parameter sets) against a
// cycle-level behavioural model of the hazard rules.
module tb_pipe_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] rs1_d, rs2_d, rd_e;
   logic       memread_e, pcsrc_e, dmem_req_m, dmem_ready_m;

   logic        en_f0, en_d0, en_e0, en_m0, en_w0, flush_d0, flush_e0, mem_err0;
   logic [31:0] stall_cnt0;
   logic        en_f1, en_d1, en_e1, en_m1, en_w1, flush_d1, flush_e1, mem_err1;
   logic [3:0]  stall_cnt1;

   int n_chk = 0;
   int n_bad = 0;

   // model state per instance: sticky error, frozen-run length, stall count
   bit     m_err [2];
   int     m_run [2];
   longint m_cnt [2];
   int     m_to  [2] = '{16, 4};
   longint m_max [2] = '{64'hFFFF_FFFF, 64'd15};

   pipe_ctrl dut0 (
      .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
      .memread_e(memread_e), .pcsrc_e(pcsrc_e), .dmem_req_m(dmem_req_m),
      .dmem_ready_m(dmem_ready_m), .en_f(en_f0), .en_d(en_d0), .en_e(en_e0),
      .en_m(en_m0), .en_w(en_w0), .flush_d(flush_d0), .flush_e(flush_e0),
      .mem_err(mem_err0), .stall_cnt(stall_cnt0)
   );

   pipe_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
      .memread_e(memread_e), .pcsrc_e(pcsrc_e), .dmem_req_m(dmem_req_m),
      .dmem_ready_m(dmem_ready_m), .en_f(en_f1), .en_d(en_d1), .en_e(en_e1),
      .en_m(en_m1), .en_w(en_w1), .flush_d(flush_d1), .flush_e(flush_e1),
      .mem_err(mem_err1), .stall_cnt(stall_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // {en_f,en_d,en_e,en_m,en_w,flush_d,flush_e,mem_err}
   function automatic logic [7:0] exp_vec(bit r, bit err, bit lw, bit pc, bit fr);
      if (r)
         return 8'h00;
      else if (err)
         return 8'h01;
      else if (fr)
         return 8'h00;
      else
         return {!lw, !lw, 1'b1, 1'b1, 1'b1, pc, lw | pc, 1'b0};
   endfunction

   task automatic tick(input bit r, input bit mr, input bit pc, input bit rq,
                       input bit rdy, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d);
      bit lw, fr, stalled;
      logic [7:0] got;
      reset = r; memread_e = mr; pcsrc_e = pc; dmem_req_m = rq;
      dmem_ready_m = rdy; rs1_d = a; rs2_d = b; rd_e = d;
      if (r) begin
         for (int i = 0; i < 2; i++) begin
            m_err[i] = 1'b0; m_run[i] = 0; m_cnt[i] = 0;
         end
      end
      #2;
      lw = mr && (d != 5'd0) && ((d == a) || (d == b));
      fr = rq && !rdy;
      for (int i = 0; i < 2; i++) begin
         got = (i == 0) ? {en_f0, en_d0, en_e0, en_m0, en_w0, flush_d0, flush_e0, mem_err0}
                        : {en_f1, en_d1, en_e1, en_m1, en_w1, flush_d1, flush_e1, mem_err1};
         chk($sformatf("outs%0d", i), {56'd0, got}, {56'd0, exp_vec(r, m_err[i], lw, pc, fr)});
         chk($sformatf("cnt%0d", i), (i == 0) ? {32'd0, stall_cnt0} : {60'd0, stall_cnt1},
             m_cnt[i]);
      end
      @(posedge clk);
      if (!r) begin
         for (int i = 0; i < 2; i++) begin
            stalled = m_err[i] || fr || lw;
            if (stalled && (m_cnt[i] < m_max[i])) m_cnt[i]++;
            if (!m_err[i]) begin
               if (fr) begin
                  m_run[i]++;
                  if (m_run[i] == m_to[i]) m_err[i] = 1'b1;
               end else begin
                  m_run[i] = 0;
               end
            end
         end
      end
      #1;
   endtask

   initial begin
      int wait_left;
      bit rq, rdy;
      wait_left = 0;

      // reset, then load-use on rs1
      tick(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
      tick(0, 1, 0, 0, 1, 5'd5, 5'd1, 5'd5);
      chk("lu_cnt", {32'd0, stall_cnt0}, 64'd1);
      // x0 never hazards; unrelated registers
      tick(0, 1, 0, 0, 1, 5'd0, 5'd7, 5'd0);
      tick(0, 1, 0, 0, 1, 5'd1, 5'd4, 5'd3);
      // branch alone, then branch with load-use on rs2
      tick(0, 0, 1, 0, 1, 5'd2, 5'd3, 5'd2);
      tick(0, 1, 1, 1, 1, 5'd2, 5'd9, 5'd9);
      // 3-cycle memory wait with a held redirect, released on ready
      tick(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
      for (int k = 0; k < 3; k++) tick(0, 0, 1, 1, 0, 5'd1, 5'd2, 5'd3);
      chk("wait_cnt", {32'd0, stall_cnt0}, 64'd3);
      tick(0, 0, 1, 1, 1, 5'd1, 5'd2, 5'd3);
      chk("wait_rel", {56'd0, en_e0, flush_d0, flush_e0}, 64'd7);
      // watchdog on the TIMEOUT=4 instance
      tick(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
      for (int k = 0; k < 4; k++) tick(0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3);
      chk("to_err1", {63'd0, mem_err1}, 64'd1);
      chk("to_err0", {63'd0, mem_err0}, 64'd0);
      tick(0, 0, 0, 1, 1, 5'd1, 5'd2, 5'd3);
      tick(0, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3);
      tick(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
      chk("to_clr", {59'd0, mem_err1, stall_cnt1}, 64'd0);
      // counter saturation on the 4-bit instance
      for (int k = 0; k < 20; k++) tick(0, 1, 0, 0, 1, 5'd5, 5'd0, 5'd5);
      chk("sat1", {60'd0, stall_cnt1}, 64'd15);
      chk("sat0", {32'd0, stall_cnt0}, 64'd20);

      // randomized traffic with occasional long memory waits and resets
      for (int k = 0; k < 3000; k++) begin
         if (wait_left > 0) begin
            rq = 1'b1; rdy = 1'b0; wait_left--;
         end else if ($urandom_range(0, 9) == 0) begin
            wait_left = $urandom_range(1, 20);
            rq = 1'b1; rdy = 1'b0;
         end else begin
            rq = 1'($urandom); rdy = ($urandom_range(0, 3) != 0);
         end
         tick($urandom_range(0, 149) == 0, 1'($urandom), $urandom_range(0, 4) == 0, rq, rdy,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
